fsm_sequenciador_linha: RTL and testbench

- Station sequencer for the bottling line. It drives the conveyor, places each bottle at the filling head, and hands it to the filling FSM through GARRAFA_PRESENTE / GARRAFA_CHEIA.
- After filling it times the corking actuator, releases the bottle and counts bottles per box.
- It sits above the filling FSM and owns the only signal that starts a fill. Stuck fills and bottles lost mid-fill are trapped in a sticky error state.

---
 rtl/fsm_sequenciador_linha.sv | 116 +++++++++++
 tb/tb_fsm_sequenciador_linha.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_sequenciador_linha.sv
// Bottling-line station sequencer: conveyor, fill hand-off, corking timer and per-box counting.
// Sits above the filling FSM; stuck or lost fills latch into a sticky error state.
module fsm_sequenciador_linha #(
    parameter int unsigned TIMEOUT_ENCHER = 1000,
    parameter int unsigned TEMPO_ROLHA    = 50,
    parameter int unsigned LOTE           = 12,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SENSOR_POSICAO,
    input  logic             GARRAFA_CHEIA,
    output logic             MOTOR_ESTEIRA,
    output logic             GARRAFA_PRESENTE,
    output logic             ATUADOR_ROLHA,
    output logic             CAIXA_COMPLETA,
    output logic             ERRO_TIMEOUT,
    output logic [CNT_W-1:0] CONTADOR_GARRAFAS
);

    localparam int unsigned TMAX = (TIMEOUT_ENCHER > TEMPO_ROLHA) ? TIMEOUT_ENCHER : TEMPO_ROLHA;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]    FIM_ENCHER = TW'(TIMEOUT_ENCHER - 1);
    localparam logic [TW-1:0]    FIM_ROLHA  = TW'(TEMPO_ROLHA - 1);
    localparam logic [CNT_W-1:0] LOTE_CNT   = CNT_W'(LOTE);

    typedef enum logic [2:0] {
        StParado   = 3'd0,
        StAvancar  = 3'd1,
        StEncher   = 3'd2,
        StArrolhar = 3'd3,
        StLiberar  = 3'd4,
        StErro     = 3'd5
    } estado_e;

    estado_e          estado_q, estado_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] contador_q, contador_d;
    logic [CNT_W-1:0] contador_inc;
    logic             caixa_q, caixa_d;

    always_comb begin
        estado_d     = estado_q;
        timer_d      = '0;
        contador_d   = contador_q;
        contador_inc = contador_q + CNT_W'(1);
        caixa_d      = 1'b0;

        case (estado_q)
            StParado: begin
                if (START) estado_d = StAvancar;
            end
            StAvancar: begin
                // A stop request beats a bottle arriving in the same cycle.
                if (!START)              estado_d = StParado;
                else if (SENSOR_POSICAO) estado_d = StEncher;
            end
            StEncher: begin
                timer_d = timer_q + TW'(1);
                if (GARRAFA_CHEIA)              estado_d = StArrolhar;
                else if (!SENSOR_POSICAO)       estado_d = StErro;
                else if (timer_q == FIM_ENCHER) estado_d = StErro;
            end
            StArrolhar: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == FIM_ROLHA) begin
                    estado_d = StLiberar;
                    if (contador_inc == LOTE_CNT) begin
                        contador_d = '0;
                        caixa_d    = 1'b1;
                    end else begin
                        contador_d = contador_inc;
                    end
                end
            end
            StLiberar: begin
                // The released bottle must clear the sensor before anything else happens.
                if (!SENSOR_POSICAO) estado_d = START ? StAvancar : StParado;
            end
            StErro: begin
                estado_d = StErro;
            end
            default: begin
                estado_d = StParado;
            end
        endcase

        if (estado_d != estado_q) timer_d = '0;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            estado_q   <= StParado;
            timer_q    <= '0;
            contador_q <= '0;
            caixa_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            contador_q <= contador_d;
            caixa_q    <= caixa_d;
        end
    end

    always_comb begin
        MOTOR_ESTEIRA     = (estado_q == StAvancar) || (estado_q == StLiberar);
        GARRAFA_PRESENTE  = (estado_q == StEncher) || (estado_q == StArrolhar);
        ATUADOR_ROLHA     = (estado_q == StArrolhar);
        ERRO_TIMEOUT      = (estado_q == StErro);
        CAIXA_COMPLETA    = caixa_q;
        CONTADOR_GARRAFAS = contador_q;
    end

endmodule

// File: tb/tb_fsm_sequenciador_linha.sv
// Bench for fsm_sequenciador_linha: directed scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against a phase/age reference model.
module tb_fsm_sequenciador_linha;

    localparam int TO = 20;
    localparam int TR = 4;
    localparam int LT = 3;
    localparam int CW = 8;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic          SENSOR_POSICAO = 1'b0;
    logic          GARRAFA_CHEIA = 1'b0;
    logic          MOTOR_ESTEIRA;
    logic          GARRAFA_PRESENTE;
    logic          ATUADOR_ROLHA;
    logic          CAIXA_COMPLETA;
    logic          ERRO_TIMEOUT;
    logic [CW-1:0] CONTADOR_GARRAFAS;

    fsm_sequenciador_linha #(
        .TIMEOUT_ENCHER(TO),
        .TEMPO_ROLHA   (TR),
        .LOTE          (LT),
        .CNT_W         (CW)
    ) dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .START            (START),
        .SENSOR_POSICAO   (SENSOR_POSICAO),
        .GARRAFA_CHEIA    (GARRAFA_CHEIA),
        .MOTOR_ESTEIRA    (MOTOR_ESTEIRA),
        .GARRAFA_PRESENTE (GARRAFA_PRESENTE),
        .ATUADOR_ROLHA    (ATUADOR_ROLHA),
        .CAIXA_COMPLETA   (CAIXA_COMPLETA),
        .ERRO_TIMEOUT     (ERRO_TIMEOUT),
        .CONTADOR_GARRAFAS(CONTADOR_GARRAFAS)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nome, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nome, got, want, $time);
        end
    endtask

    // Reference model: which phase of the bottle cycle we are in and how long we have been there.
    localparam int P_STOP  = 0;
    localparam int P_MOVE  = 1;
    localparam int P_FILL  = 2;
    localparam int P_CORK  = 3;
    localparam int P_REL   = 4;
    localparam int P_FAULT = 5;

    int m_phase = P_STOP;
    int m_age   = 0;
    int m_count = 0;
    bit m_box   = 1'b0;
    int m_next;

    function automatic int nxt(input int ph, input int age, input bit st, input bit sen,
                               input bit ful);
        int r;
        r = ph;
        if (ph == P_STOP) begin
            if (st) r = P_MOVE;
        end else if (ph == P_MOVE) begin
            if (!st) r = P_STOP;
            else if (sen) r = P_FILL;
        end else if (ph == P_FILL) begin
            // age+1 = number of fill cycles including the current one
            if (ful) r = P_CORK;
            else if (!sen || (age + 1 == TO)) r = P_FAULT;
        end else if (ph == P_CORK) begin
            if (age + 1 == TR) r = P_REL;
        end else if (ph == P_REL) begin
            if (!sen) r = st ? P_MOVE : P_STOP;
        end
        return r;
    endfunction

    always_comb m_next = nxt(m_phase, m_age, START, SENSOR_POSICAO, GARRAFA_CHEIA);

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            m_phase <= P_STOP;
            m_age   <= 0;
            m_count <= 0;
            m_box   <= 1'b0;
        end else begin
            m_box   <= 1'b0;
            m_age   <= (m_next == m_phase) ? m_age + 1 : 0;
            m_phase <= m_next;
            if (m_phase == P_CORK && m_next == P_REL) begin
                if (m_count + 1 == LT) begin
                    m_count <= 0;
                    m_box   <= 1'b1;
                end else begin
                    m_count <= m_count + 1;
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        chk("motor", int'(MOTOR_ESTEIRA), int'(m_phase == P_MOVE || m_phase == P_REL));
        chk("presente", int'(GARRAFA_PRESENTE), int'(m_phase == P_FILL || m_phase == P_CORK));
        chk("rolha", int'(ATUADOR_ROLHA), int'(m_phase == P_CORK));
        chk("erro", int'(ERRO_TIMEOUT), int'(m_phase == P_FAULT));
        chk("caixa", int'(CAIXA_COMPLETA), int'(m_box));
        chk("contador", int'(CONTADOR_GARRAFAS), m_count);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #2;
        end
    endtask

    task automatic chk_all_zero(input string nome);
        chk(nome, int'({MOTOR_ESTEIRA, GARRAFA_PRESENTE, ATUADOR_ROLHA, CAIXA_COMPLETA,
                        ERRO_TIMEOUT}), 0);
        chk({nome, "_cnt"}, int'(CONTADOR_GARRAFAS), 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk_all_zero("reset_async");
        START          = 1'b1;
        SENSOR_POSICAO = 1'b0;
        GARRAFA_CHEIA  = 1'b0;
        tick(1);
        RESET = 1'b0;
        tick(1);
    endtask

    // From AVANCAR: bottle arrives, fills after 'atraso'+1 cycles, returns the corking length.
    task automatic garrafa(input int atraso, output int rolha_ciclos);
        tick(4);
        SENSOR_POSICAO = 1'b1;
        tick(1);
        chk("g_motor_off", int'(MOTOR_ESTEIRA), 0);
        chk("g_presente", int'(GARRAFA_PRESENTE), 1);
        tick(atraso);
        GARRAFA_CHEIA = 1'b1;
        tick(1);
        rolha_ciclos = 0;
        while (ATUADOR_ROLHA && rolha_ciclos < 50) begin
            rolha_ciclos++;
            tick(1);
        end
        chk("g_motor_on", int'(MOTOR_ESTEIRA), 1);
    endtask

    task automatic soltar();
        SENSOR_POSICAO = 1'b0;
        GARRAFA_CHEIA  = 1'b0;
        tick(1);
    endtask

    initial begin
        int r;
        tick(2);
        chk_all_zero("reset");
        RESET = 1'b0;
        tick(1);

        // Normal bottle
        START = 1'b1;
        tick(1);
        chk("t1_motor", int'(MOTOR_ESTEIRA), 1);
        garrafa(5, r);
        chk("t1_rolha_len", r, 4);
        chk("t1_cnt", int'(CONTADOR_GARRAFAS), 1);
        chk("t1_caixa", int'(CAIXA_COMPLETA), 0);
        soltar();

        // Box completion
        garrafa(2, r);
        chk("t2_cnt2", int'(CONTADOR_GARRAFAS), 2);
        soltar();
        garrafa(0, r);
        chk("t2_cnt_wrap", int'(CONTADOR_GARRAFAS), 0);
        chk("t2_caixa_on", int'(CAIXA_COMPLETA), 1);
        soltar();
        chk("t2_caixa_off", int'(CAIXA_COMPLETA), 0);

        // Timeout, sticky through START toggling, counter held
        garrafa(1, r);
        soltar();
        SENSOR_POSICAO = 1'b1;
        tick(1);
        tick(TO - 1);
        chk("t3_pre_erro", int'(ERRO_TIMEOUT), 0);
        chk("t3_pre_presente", int'(GARRAFA_PRESENTE), 1);
        tick(1);
        chk("t3_erro", int'(ERRO_TIMEOUT), 1);
        chk("t3_act", int'({MOTOR_ESTEIRA, GARRAFA_PRESENTE, ATUADOR_ROLHA}), 0);
        for (int i = 0; i < 6; i++) begin
            START = ~START;
            tick(1);
        end
        chk("t3_sticky", int'(ERRO_TIMEOUT), 1);
        chk("t3_cnt_held", int'(CONTADOR_GARRAFAS), 1);
        do_reset();

        // Timeout boundary: fill in final cycle wins, otherwise error
        SENSOR_POSICAO = 1'b1;
        tick(1);
        tick(TO - 1);
        GARRAFA_CHEIA = 1'b1;
        tick(1);
        chk("t4_rolha", int'(ATUADOR_ROLHA), 1);
        chk("t4_no_erro", int'(ERRO_TIMEOUT), 0);
        tick(TR);
        chk("t4_liberar", int'(MOTOR_ESTEIRA), 1);
        soltar();
        SENSOR_POSICAO = 1'b1;
        tick(1);
        tick(TO - 1);
        tick(1);
        chk("t4_erro", int'(ERRO_TIMEOUT), 1);
        do_reset();

        // Bottle lost mid-fill
        SENSOR_POSICAO = 1'b1;
        tick(1);
        tick(3);
        SENSOR_POSICAO = 1'b0;
        tick(1);
        chk("t5_erro", int'(ERRO_TIMEOUT), 1);
        chk("t5_presente", int'(GARRAFA_PRESENTE), 0);
        do_reset();

        // Stop during fill: bottle completes, waits for clear, then parks
        SENSOR_POSICAO = 1'b1;
        tick(1);
        tick(2);
        START = 1'b0;
        tick(3);
        GARRAFA_CHEIA = 1'b1;
        tick(1);
        chk("t6_rolha", int'(ATUADOR_ROLHA), 1);
        tick(TR);
        chk("t6_liberar", int'(MOTOR_ESTEIRA), 1);
        chk("t6_cnt", int'(CONTADOR_GARRAFAS), 1);
        tick(2);
        chk("t6_espera", int'(MOTOR_ESTEIRA), 1);
        soltar();
        chk("t6_parado", int'(MOTOR_ESTEIRA), 0);
        tick(2);
        chk("t6_parado2", int'(MOTOR_ESTEIRA), 0);

        // Async reset in the middle of corking
        START = 1'b1;
        tick(1);
        SENSOR_POSICAO = 1'b1;
        tick(1);
        GARRAFA_CHEIA = 1'b1;
        tick(2);
        chk("t6_rolha2", int'(ATUADOR_ROLHA), 1);
        do_reset();

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            RESET = (m_phase == P_FAULT && $urandom_range(0, 9) == 0) ||
                    ($urandom_range(0, 499) == 0);
            START = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) SENSOR_POSICAO = ~SENSOR_POSICAO;
            GARRAFA_CHEIA = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        RESET = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
